// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types for the IF/MEM main-memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Pipeline imem/dmem ports plus the shared downstream memory port.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  imem_read;
    logic [ADDR_W-1:0]     imem_addr;
    logic                  imem_resp;
    logic [DATA_W-1:0]     imem_rdata;

    logic                  dmem_read;
    logic                  dmem_write;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W/8-1:0]   dmem_wmask;
    logic                  dmem_resp;
    logic [DATA_W-1:0]     dmem_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter view
    modport slave (
        input  imem_read, imem_addr,
        input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_wmask,
        input  mem_resp, mem_rdata,
        output imem_resp, imem_rdata, dmem_resp, dmem_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
    );

    // Environment view: pipeline requesters and downstream memory
    modport master (
        output imem_read, imem_addr,
        output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_wmask,
        output mem_resp, mem_rdata,
        input  imem_resp, imem_rdata, dmem_resp, dmem_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Round-robin arbiter sharing one memory port between IF and MEM.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mem_port_arbiter_if.slave      bus
);

    localparam int c_mask_w = DATA_W / 8;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    requester_t              r_last_grant;
    logic                    r_is_write;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [c_mask_w-1:0]     r_wmask;
    logic [DATA_W-1:0]       r_imem_rdata;
    logic [DATA_W-1:0]       r_dmem_rdata;

    logic                    w_i_req;
    logic                    w_d_req;
    logic                    w_grant_d;
    logic                    w_grant_i;
    logic                    w_busy;
    logic                    w_mem_read;
    logic                    w_mem_write;
    logic                    w_imem_resp;
    logic                    w_dmem_resp;

    assign w_i_req   = bus.imem_read;
    assign w_d_req   = bus.dmem_read | bus.dmem_write;
    // On a tie the requester that did not win last time gets the port.
    assign w_grant_d = (r_state == IDLE) && w_d_req && (!w_i_req || (r_last_grant == REQ_I));
    assign w_grant_i = (r_state == IDLE) && w_i_req && !w_grant_d;
    assign w_busy    = (r_state == I_BUSY) || (r_state == D_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = D_BUSY;
                end else if (w_grant_i) begin
                    w_state_nxt = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_resp) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_imem_resp = 1'b0;
        w_dmem_resp = 1'b0;
        unique case (r_state)
            I_BUSY:  w_mem_read  = 1'b1;
            D_BUSY: begin
                w_mem_read  = !r_is_write;
                w_mem_write = r_is_write;
            end
            DONE: begin
                w_imem_resp = (r_last_grant == REQ_I);
                w_dmem_resp = (r_last_grant == REQ_D);
            end
            default: ;
        endcase
    end

    // Request fields are captured once at grant; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_I;
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_imem_rdata <= '0;
            r_dmem_rdata <= '0;
        end else begin
            if (w_grant_d) begin
                r_last_grant <= REQ_D;
                r_is_write   <= bus.dmem_write;
                r_addr       <= bus.dmem_addr;
                r_wdata      <= bus.dmem_wdata;
                r_wmask      <= bus.dmem_write ? bus.dmem_wmask : '0;
            end else if (w_grant_i) begin
                r_last_grant <= REQ_I;
                r_is_write   <= 1'b0;
                r_addr       <= bus.imem_addr;
                r_wdata      <= '0;
                r_wmask      <= '0;
            end
            if (w_busy && bus.mem_resp) begin
                if (r_last_grant == REQ_I) begin
                    r_imem_rdata <= bus.mem_rdata;
                end else begin
                    r_dmem_rdata <= r_is_write ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.mem_wmask  = r_wmask;
    assign bus.imem_resp  = w_imem_resp;
    assign bus.imem_rdata = r_imem_rdata;
    assign bus.dmem_resp  = w_dmem_resp;
    assign bus.dmem_rdata = r_dmem_rdata;

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.dmem_read && bus.dmem_write));
    a_resp_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_resp |-> w_busy);
    a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_imem_resp && w_dmem_resp));
    a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_mem_read && w_mem_write));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.imem_read  = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_read  = 1'b0;
        bus.dmem_write = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_wmask = '0;
        bus.mem_resp   = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    // Entered at the negedge of the first busy cycle; returns at the DONE negedge.
    task automatic txn(input string tag, input bit is_d, input bit is_w,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int lat, input logic [31:0] rdata);
        for (int k = 1; k <= lat; k++) begin
            chk({tag, ".rd"},   32'(bus.mem_read),  32'(!is_w));
            chk({tag, ".wr"},   32'(bus.mem_write), 32'(is_w));
            chk({tag, ".addr"}, bus.mem_addr, addr);
            chk({tag, ".mask"}, 32'(bus.mem_wmask), 32'(is_w ? wmask : 4'h0));
            if (is_w) chk({tag, ".wdata"}, bus.mem_wdata, wdata);
            chk({tag, ".noresp"}, 32'(bus.imem_resp | bus.dmem_resp), 32'h0);
            if (k == lat) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = rdata;
            end
            @(negedge clk);
        end
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        chk({tag, ".iresp"},  32'(bus.imem_resp), 32'(!is_d));
        chk({tag, ".dresp"},  32'(bus.dmem_resp), 32'(is_d));
        chk({tag, ".done_strobe"}, 32'(bus.mem_read | bus.mem_write), 32'h0);
        if (is_d) chk({tag, ".drdata"}, bus.dmem_rdata, is_w ? 32'h0 : rdata);
        else      chk({tag, ".irdata"}, bus.imem_rdata, rdata);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.mem_read",  32'(bus.mem_read),  32'h0);
        chk("reset.mem_write", 32'(bus.mem_write), 32'h0);
        chk("reset.resp",      32'(bus.imem_resp | bus.dmem_resp), 32'h0);
        chk("reset.mem_addr",  bus.mem_addr,   32'h0);
        chk("reset.imem_rdata", bus.imem_rdata, 32'h0);
        chk("reset.dmem_rdata", bus.dmem_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie straight after reset: D first, then I
        bus.imem_read = 1'b1; bus.imem_addr = 32'h100;
        bus.dmem_read = 1'b1; bus.dmem_addr = 32'h200;
        @(negedge clk);
        txn("tie_d", 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1, 32'hD0D0_0001);
        bus.dmem_read = 1'b0;
        @(negedge clk);
        chk("tie.bubble", 32'(bus.mem_read | bus.mem_write), 32'h0);
        @(negedge clk);
        txn("tie_i", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h1111_0002);
        bus.imem_read = 1'b0;
        @(negedge clk);

        // Store with requester inputs changing mid-transaction
        bus.dmem_write = 1'b1; bus.dmem_addr = 32'h1004;
        bus.dmem_wdata = 32'h0000_AB00; bus.dmem_wmask = 4'b0010;
        @(negedge clk);
        bus.dmem_addr = 32'hDEAD_BEEF; bus.dmem_wdata = 32'hFFFF_FFFF; bus.dmem_wmask = 4'hF;
        txn("store", 1'b1, 1'b1, 32'h1004, 32'h0000_AB00, 4'b0010, 2, 32'h5555_5555);
        bus.dmem_write = 1'b0; bus.dmem_wmask = 4'h0;
        @(negedge clk);

        // Lone fetch, 3 strobe cycles
        bus.imem_read = 1'b1; bus.imem_addr = 32'h6000_0000;
        @(negedge clk);
        txn("fetch", 1'b0, 1'b0, 32'h6000_0000, 32'h0, 4'h0, 3, 32'h0000_0013);
        bus.imem_read = 1'b0;
        @(negedge clk);
        chk("fetch.resp_low",  32'(bus.imem_resp), 32'h0);
        chk("fetch.rdata_hold", bus.imem_rdata, 32'h0000_0013);
        chk("fetch.idle_rd",   32'(bus.mem_read), 32'h0);

        // Continuous contention: D,I,D,I,D,I
        bus.imem_read = 1'b1; bus.imem_addr = 32'h300;
        bus.dmem_read = 1'b1; bus.dmem_addr = 32'h400;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            txn($sformatf("cont%0d", i), (i % 2) == 0, 1'b0,
                ((i % 2) == 0) ? 32'h400 : 32'h300, 32'h0, 4'h0, 1, 32'hC000_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("cont%0d.bubble", i), 32'(bus.mem_read | bus.mem_write | bus.imem_resp | bus.dmem_resp), 32'h0);
        end
        bus.imem_read = 1'b0; bus.dmem_read = 1'b0;
        @(negedge clk);

        // Stale request held through DONE: no grant until the following IDLE
        bus.dmem_read = 1'b1; bus.dmem_addr = 32'h500;
        @(negedge clk);
        txn("stale", 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1, 32'h6666_0006);
        @(negedge clk);
        chk("stale.idle_rd", 32'(bus.mem_read), 32'h0);
        @(negedge clk);
        txn("regrant", 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1, 32'h7777_0007);
        bus.dmem_read = 1'b0;
        @(negedge clk);

        // Asynchronous reset during a store
        bus.dmem_write = 1'b1; bus.dmem_addr = 32'h800;
        bus.dmem_wdata = 32'h1234_5678; bus.dmem_wmask = 4'hF;
        @(negedge clk);
        chk("rst.pre_write", 32'(bus.mem_write), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.mem_write",  32'(bus.mem_write), 32'h0);
        chk("rst.mem_addr",   bus.mem_addr,  32'h0);
        chk("rst.mem_wdata",  bus.mem_wdata, 32'h0);
        chk("rst.mem_wmask",  32'(bus.mem_wmask), 32'h0);
        chk("rst.imem_rdata", bus.imem_rdata, 32'h0);
        chk("rst.dmem_rdata", bus.dmem_rdata, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_read = 1'b1; bus.imem_addr = 32'h900;
        bus.dmem_read = 1'b1; bus.dmem_addr = 32'hA00;
        @(negedge clk);
        txn("post_rst_tie", 1'b1, 1'b0, 32'hA00, 32'h0, 4'h0, 1, 32'hAAAA_000A);
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
